// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, registers instr memory data into IR, hands it to decode.
// Optional macro FETCH_BOUND_EN stops fetching at MEM_DEPTH and parks the unit in HALT.
module instr_fetch_unit #(
    parameter int                PC_W      = 8,
    parameter int                INSTR_W   = 8,
    parameter int                MEM_DEPTH = 9,
    parameter logic [PC_W-1:0]   RESET_PC  = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr_code,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect_en,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [7:0]         instr_count,
    output logic               halted
);

`ifdef FETCH_BOUND_EN
    localparam bit LP_BOUND_EN = 1'b1;
`else
    localparam bit LP_BOUND_EN = 1'b0;
`endif
    localparam logic [PC_W:0] LP_DEPTH = MEM_DEPTH[PC_W:0];

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [PC_W-1:0]    r_ir_pc;
    logic               r_ir_valid;
    logic [7:0]         r_count;
    logic               w_load;
    logic               w_bound;
    logic               w_fetch;
    logic               w_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = (r_state == S_RUN) && (!r_ir_valid || ir_ready);
        w_bound     = LP_BOUND_EN && w_load && ({1'b0, r_pc} >= LP_DEPTH);
        w_fetch     = w_load && !w_bound;
        w_accept    = r_ir_valid && ir_ready && !redirect_en;
        if (redirect_en) begin
            w_state_nxt = fetch_en ? S_RUN : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (fetch_en) w_state_nxt = S_RUN;
                S_RUN: begin
                    if (w_bound)        w_state_nxt = S_HALT;
                    else if (!fetch_en) w_state_nxt = S_IDLE;
                end
                S_HALT:  w_state_nxt = S_HALT;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_count    <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && (r_count != 8'hFF)) r_count <= r_count + 8'd1;
            // A redirect flushes the IR even if decode is taking it this cycle.
            if (redirect_en) begin
                r_pc       <= redirect_pc;
                r_ir_valid <= 1'b0;
            end else if (w_fetch) begin
                r_ir       <= instr_code;
                r_ir_pc    <= r_pc;
                r_ir_valid <= 1'b1;
                r_pc       <= r_pc + 1'b1;
            end else if (r_ir_valid && ir_ready) begin
                r_ir_valid <= 1'b0;
            end
        end
    end

    assign pc          = r_pc;
    assign ir          = r_ir;
    assign ir_pc       = r_ir_pc;
    assign ir_valid    = r_ir_valid;
    assign instr_count = r_count;
    assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational instruction memory model.
module tb_instr_fetch_unit;

    logic       clk;
    logic       reset;
    logic       fetch_en;
    logic [7:0] pc;
    logic [7:0] instr_code;
    logic [7:0] ir;
    logic [7:0] ir_pc;
    logic       ir_valid;
    logic       ir_ready;
    logic       redirect_en;
    logic [7:0] redirect_pc;
    logic [7:0] instr_count;
    logic       halted;

    logic [7:0] mem [0:255];
    int n_chk  = 0;
    int n_pass = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .pc          (pc),
        .instr_code  (instr_code),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .instr_count (instr_count),
        .halted      (halted)
    );

    assign instr_code = mem[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_pc",    32'(pc), 32'h00);
        chk("rst_ir",    32'(ir), 32'h00);
        chk("rst_irpc",  32'(ir_pc), 32'h00);
        chk("rst_valid", 32'(ir_valid), 32'h0);
        chk("rst_count", 32'(instr_count), 32'h00);
        chk("rst_halt",  32'(halted), 32'h0);
    endtask

    initial begin
        logic [7:0] prog [0:5];
        prog[0] = 8'h13; prog[1] = 8'h51; prog[2] = 8'h0A;
        prog[3] = 8'hC5; prog[4] = 8'h4B; prog[5] = 8'h3C;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 6; i++) mem[i] = prog[i];
        mem[255] = 8'h77;

        reset = 1'b0; fetch_en = 1'b0; ir_ready = 1'b0;
        redirect_en = 1'b0; redirect_pc = 8'h00;
        #12;
        chk_reset_vals();
        reset = 1'b1; fetch_en = 1'b1; ir_ready = 1'b1;

        // Streaming fetch: first edge enters RUN, then one instruction per cycle
        step();
        chk("t1_idle_valid", 32'(ir_valid), 32'h0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t1_ir",    32'(ir), 32'(prog[k]));
            chk("t1_irpc",  32'(ir_pc), 32'(k));
            chk("t1_count", 32'(instr_count), 32'(k));
        end
        step();
        chk("t1_count6", 32'(instr_count), 32'h6);
        chk("t1_pc7",    32'(pc), 32'h7);

        // Redirect to 2, then stall on 0x0A
        redirect_en = 1'b1; redirect_pc = 8'h02;
        step();
        chk("t2_rd_valid", 32'(ir_valid), 32'h0);
        chk("t2_rd_pc",    32'(pc), 32'h2);
        chk("t2_rd_count", 32'(instr_count), 32'h6);
        redirect_en = 1'b0;
        step();
        chk("t2_ir", 32'(ir), 32'h0A);
        ir_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_st_ir",    32'(ir), 32'h0A);
            chk("t2_st_irpc",  32'(ir_pc), 32'h2);
            chk("t2_st_pc",    32'(pc), 32'h3);
            chk("t2_st_count", 32'(instr_count), 32'h6);
        end
        ir_ready = 1'b1;
        step();
        chk("t2_rel_ir",    32'(ir), 32'hC5);
        chk("t2_rel_count", 32'(instr_count), 32'h7);

        // Redirect while 0x51 is valid and being accepted
        redirect_en = 1'b1; redirect_pc = 8'h01;
        step();
        redirect_en = 1'b0;
        step();
        chk("t3_ir51", 32'(ir), 32'h51);
        redirect_en = 1'b1; redirect_pc = 8'h04;
        step();
        chk("t3_valid", 32'(ir_valid), 32'h0);
        chk("t3_pc",    32'(pc), 32'h4);
        chk("t3_count", 32'(instr_count), 32'h7);
        redirect_en = 1'b0;
        step();
        chk("t3_ir4b",  32'(ir), 32'h4B);
        chk("t3_irpc",  32'(ir_pc), 32'h4);

`ifdef FETCH_BOUND_EN
        redirect_en = 1'b1; redirect_pc = 8'h00;
        step();
        redirect_en = 1'b0;
        for (int k = 0; k < 9; k++) step();
        chk("t4_last_irpc", 32'(ir_pc), 32'h8);
        chk("t4_pc9",       32'(pc), 32'h9);
        step();
        chk("t4_halted", 32'(halted), 32'h1);
        chk("t4_drain",  32'(ir_valid), 32'h0);
        step();
        chk("t4_pc_hold", 32'(pc), 32'h9);
        redirect_en = 1'b1; redirect_pc = 8'h00;
        step();
        chk("t4_unhalt", 32'(halted), 32'h0);
        redirect_en = 1'b0;
        step();
        chk("t4_ir13", 32'(ir), 32'h13);
`else
        // Wrap at 0xFF, then drop fetch_en and drain
        redirect_en = 1'b1; redirect_pc = 8'hFF;
        step();
        chk("t5_pcff", 32'(pc), 32'hFF);
        redirect_en = 1'b0;
        step();
        chk("t5_ir77",  32'(ir), 32'h77);
        chk("t5_irpc",  32'(ir_pc), 32'hFF);
        chk("t5_wrap",  32'(pc), 32'h00);
        chk("t5_halt",  32'(halted), 32'h0);
        fetch_en = 1'b0; ir_ready = 1'b0;
        step();
        chk("t5_idle_pc",  32'(pc), 32'h00);
        chk("t5_idle_vld", 32'(ir_valid), 32'h1);
        ir_ready = 1'b1;
        step();
        chk("t5_drain",    32'(ir_valid), 32'h0);
        chk("t5_count",    32'(instr_count), 32'h8);
        step();
        chk("t5_pc_frz",   32'(pc), 32'h00);
`endif

        // Async reset during a stall
        fetch_en = 1'b1; ir_ready = 1'b0;
        step();
        step();
        chk("t6_pre_valid", 32'(ir_valid), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals();
        #10;
        reset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
